// File: rtl/ysyx22041405_pipe_reg_hs.sv
// Valid/ready pipeline register with optional skid entry; 1-cycle latency, 1 payload/cycle.
// Backpressure: SKID=0 passes out_ready combinationally to in_ready; SKID=1 registers in_ready as !skid_full.
module ysyx22041405_pipe_reg_hs #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      SKID       = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic             accept;
    logic             release_w;

    // rdy_q is low through reset; with SKID=0 it only marks "out of reset" since TWO is unreachable.
    if (SKID != 0) begin : g_skid
        assign in_ready = rdy_q;
    end else begin : g_pass
        assign in_ready = rdy_q & (~out_valid | out_ready);
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready & ~flush;
    assign release_w = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && release_w) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (release_w) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (release_w) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        rdy_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload storage is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_ysyx22041405_pipe_reg_hs.sv
// Bench for the pipeline register: lane 0 is the SKID=1 stage, lane 1 the SKID=0 stage, both WIDTH=64.
module tb_ysyx22041405_pipe_reg_hs;

    localparam logic [63:0] BUB = 64'hB0B0_B0B0_B0B0_B0B0;

    logic        clk;
    logic        rst;
    logic        in_valid    [2];
    logic [63:0] in_data     [2];
    logic        out_ready   [2];
    logic        flush       [2];
    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [63:0] out_data_w  [2];
    logic [1:0]  occ_w       [2];

    int errors;
    int checks;
    bit mon_en;

    ysyx22041405_pipe_reg_hs #(.WIDTH(64), .SKID(1), .BUBBLE_VAL(BUB)) u_dut_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready_w[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data_w[0]),
        .flush     (flush[0]),
        .occupancy (occ_w[0])
    );

    ysyx22041405_pipe_reg_hs #(.WIDTH(64), .SKID(0), .BUBBLE_VAL(BUB)) u_dut_pass (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready_w[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data_w[1]),
        .flush     (flush[1]),
        .occupancy (occ_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int ln, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", ln, nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int l, input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid[l]  = v;
        in_data[l]   = d;
        out_ready[l] = ordy;
        flush[l]     = fl;
    endtask

    // Scoreboard per lane: accepted payloads are queued in order, the head is compared
    // against out_data while valid, and popped on each release.
    for (genvar l = 0; l < 2; l++) begin : g_sb
        localparam bit SK = (l == 0);
        logic [63:0] sb [$];
        bit alive = 1'b0;
        always @(negedge clk) begin
            bit exp_rdy;
            bit rel;
            bit acc;
            if (mon_en) begin
                exp_rdy = alive && (SK ? (sb.size() < 2) : (sb.size() == 0 || out_ready[l]));
                chk(l, "sb_in_ready", 64'(in_ready_w[l]), 64'(exp_rdy));
                chk(l, "sb_out_valid", 64'(out_valid_w[l]), 64'(sb.size() > 0));
                chk(l, "sb_occupancy", 64'(occ_w[l]), 64'(sb.size()));
                if (sb.size() > 0) chk(l, "sb_out_data", out_data_w[l], sb[0]);
                else               chk(l, "sb_bubble", out_data_w[l], BUB);
                if (rst) begin
                    sb.delete();
                    alive = 1'b0;
                end else begin
                    rel = (sb.size() > 0) && out_ready[l];
                    acc = in_valid[l] && exp_rdy && !flush[l];
                    if (rel) void'(sb.pop_front());
                    if (flush[l])  sb.delete();
                    else if (acc)  sb.push_back(in_data[l]);
                    alive = 1'b1;
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int l = 0; l < 2; l++) drv(l, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        mon_en = 1'b1;
        cyc();
        for (int l = 0; l < 2; l++) begin
            chk(l, "rst_out_valid", 64'(out_valid_w[l]), 64'h0);
            chk(l, "rst_out_data", out_data_w[l], BUB);
            chk(l, "rst_occ", 64'(occ_w[l]), 64'h0);
            chk(l, "rst_in_ready", 64'(in_ready_w[l]), 64'h0);
        end
        rst = 1'b0;
        cyc();
        for (int l = 0; l < 2; l++) chk(l, "post_rst_in_ready", 64'(in_ready_w[l]), 64'h1);

        // Back-to-back stream through the skid stage.
        for (int k = 1; k <= 4; k++) begin
            drv(0, 1'b1, 64'(k), 1'b1, 1'b0);
            cyc();
            chk(0, "tput_data", out_data_w[0], 64'(k));
            chk(0, "tput_valid", 64'(out_valid_w[0]), 64'h1);
            chk(0, "tput_occ", 64'(occ_w[0]), 64'h1);
        end
        drv(0, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc();
        chk(0, "tput_drain_valid", 64'(out_valid_w[0]), 64'h0);
        chk(0, "tput_drain_data", out_data_w[0], BUB);

        // Stall fills main then skid; extra push is ignored.
        drv(0, 1'b1, 64'hA, 1'b0, 1'b0);
        cyc();
        chk(0, "stall_occ1", 64'(occ_w[0]), 64'h1);
        chk(0, "stall_rdy1", 64'(in_ready_w[0]), 64'h1);
        drv(0, 1'b1, 64'hB, 1'b0, 1'b0);
        cyc();
        chk(0, "stall_occ2", 64'(occ_w[0]), 64'h2);
        chk(0, "stall_rdy2", 64'(in_ready_w[0]), 64'h0);
        chk(0, "stall_data_a", out_data_w[0], 64'hA);
        drv(0, 1'b1, 64'hC, 1'b0, 1'b0);
        cyc();
        chk(0, "stall_hold_occ", 64'(occ_w[0]), 64'h2);
        chk(0, "stall_hold_data", out_data_w[0], 64'hA);
        drv(0, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc();
        chk(0, "unstall_data_b", out_data_w[0], 64'hB);
        chk(0, "unstall_occ", 64'(occ_w[0]), 64'h1);
        chk(0, "unstall_rdy", 64'(in_ready_w[0]), 64'h1);
        cyc();
        chk(0, "unstall_empty", 64'(out_valid_w[0]), 64'h0);
        chk(0, "unstall_occ0", 64'(occ_w[0]), 64'h0);

        // Flush at occupancy 2 with a concurrent push.
        drv(0, 1'b1, 64'h11, 1'b0, 1'b0);
        cyc();
        drv(0, 1'b1, 64'h22, 1'b0, 1'b0);
        cyc();
        chk(0, "flush_pre_occ", 64'(occ_w[0]), 64'h2);
        drv(0, 1'b1, 64'h33, 1'b0, 1'b1);
        cyc();
        chk(0, "flush_occ", 64'(occ_w[0]), 64'h0);
        chk(0, "flush_valid", 64'(out_valid_w[0]), 64'h0);
        chk(0, "flush_data", out_data_w[0], BUB);
        drv(0, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc();
        chk(0, "flush_no_leak", 64'(out_valid_w[0]), 64'h0);
        // Flush while ready: release counts, incoming is dropped.
        drv(0, 1'b1, 64'h44, 1'b0, 1'b0);
        cyc();
        drv(0, 1'b1, 64'h55, 1'b1, 1'b1);
        cyc();
        chk(0, "flush_rdy_valid", 64'(out_valid_w[0]), 64'h0);

        // Reset at occupancy 2.
        drv(0, 1'b1, 64'h66, 1'b0, 1'b0);
        cyc();
        drv(0, 1'b1, 64'h77, 1'b0, 1'b0);
        cyc();
        chk(0, "rst2_pre_occ", 64'(occ_w[0]), 64'h2);
        drv(0, 1'b0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        chk(0, "rst2_valid", 64'(out_valid_w[0]), 64'h0);
        chk(0, "rst2_occ", 64'(occ_w[0]), 64'h0);
        chk(0, "rst2_rdy", 64'(in_ready_w[0]), 64'h0);
        rst = 1'b0;
        cyc();
        chk(0, "rst2_rdy_back", 64'(in_ready_w[0]), 64'h1);

        // Single-entry stage: combinational ready, replace without bubble.
        drv(1, 1'b1, 64'hA1, 1'b0, 1'b0);
        cyc();
        chk(1, "pass_occ", 64'(occ_w[1]), 64'h1);
        chk(1, "pass_rdy_stall", 64'(in_ready_w[1]), 64'h0);
        drv(1, 1'b1, 64'hA2, 1'b0, 1'b0);
        cyc();
        chk(1, "pass_occ_max", 64'(occ_w[1]), 64'h1);
        chk(1, "pass_hold", out_data_w[1], 64'hA1);
        drv(1, 1'b1, 64'hA3, 1'b1, 1'b0);
        #1;
        chk(1, "pass_rdy_comb", 64'(in_ready_w[1]), 64'h1);
        cyc();
        chk(1, "pass_replace", out_data_w[1], 64'hA3);
        chk(1, "pass_replace_valid", 64'(out_valid_w[1]), 64'h1);
        drv(1, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc();
        chk(1, "pass_drain", out_data_w[1], BUB);

        // Random traffic on both lanes, checked by the scoreboards.
        repeat (10000) begin
            for (int l = 0; l < 2; l++)
                drv(l, ($urandom_range(9) < 7), {$urandom, $urandom}, ($urandom_range(9) < 6), ($urandom_range(39) == 0));
            rst = ($urandom_range(999) == 0);
            cyc();
        end
        rst = 1'b0;
        for (int l = 0; l < 2; l++) drv(l, 1'b0, 64'h0, 1'b1, 1'b0);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_pipe_reg_hs.md
YSYX22041405_PIPE_REG_HS -- requirements
Module: ysyx22041405_pipe_reg_hs

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, width of the stage payload.
REQ-002 SHALL provide parameter SKID, default 1; 0 = single-entry stage with combinational in_ready, 1 = two-entry skid stage with registered in_ready.
REQ-003 SHALL provide parameter BUBBLE_VAL, default {WIDTH{1'b0}}, the payload presented when the stage is empty.
REQ-004 SHALL use one clock and a synchronous, active-high reset; clock and reset ports are named clk and rst.
REQ-005 clk  input  1  stage clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage holds a valid payload for downstream.
REQ-011 out_ready  input  1  downstream accepts the payload this cycle.
REQ-012 out_data  output  WIDTH  payload to downstream.
REQ-013 flush  input  1  discard all held and incoming payloads (branch redirect / exception).
REQ-014 occupancy  output  2  number of valid entries held (0..2).

Function
REQ-015 Accept = in_valid & in_ready & !flush at a rising edge; release = out_valid & out_ready at a rising edge.
REQ-016 Latency in->out SHALL be exactly 1 cycle when the stage is empty; sustained throughput SHALL be 1 payload/cycle while out_ready stays high.
REQ-017 Payload order SHALL be strictly preserved; no payload is duplicated or dropped except by flush.
REQ-018 While out_valid=1 and out_ready=0, out_data SHALL remain stable and out_valid SHALL remain 1 (unless flush or rst).
REQ-019 When out_valid=0, out_data SHALL equal BUBBLE_VAL.
REQ-020 SKID=0: storage is one main entry; in_ready = !out_valid | out_ready (combinational); occupancy never exceeds 1.
REQ-021 SKID=1: storage is main entry plus skid entry; in_ready SHALL be a register output equal to !skid_full, with no combinational path from out_ready.
REQ-022 SKID=1 states: EMPTY (occ 0), ONE (main valid), TWO (main+skid valid).
REQ-023 EMPTY: accept -> ONE.
REQ-024 ONE: accept & release -> ONE with new payload in main; accept only -> TWO, new payload into skid; release only -> EMPTY.
REQ-025 TWO: in_ready=0; release -> ONE, skid payload moves to main same edge; in_ready returns to 1 the following cycle.
REQ-026 flush SHALL clear main and skid valid at the next edge (state EMPTY, occupancy 0, out_data BUBBLE_VAL), dominating any simultaneous accept or release; a payload released in the flush cycle counts as delivered.
REQ-027 occupancy SHALL equal the count of valid entries after each edge; occupancy=2 only when SKID=1.
REQ-028 in_valid SHALL be ignored when in_ready=0; in_data not accepted leaves state unchanged.

Reset
REQ-029 While rst=1: out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=0; all entries invalidated at the edge.
REQ-030 First cycle after rst deasserts: in_ready=1, state EMPTY.
REQ-031 rst asserted mid-transfer or concurrently with flush SHALL produce the same result as REQ-029; held payloads are discarded.

Verification
REQ-032 SKID=1, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, out_valid continuous, occupancy 1.
REQ-033 SKID=1, out_ready=0, push A then B -> occupancy 2, in_ready=0, out_data=A stable; raise out_ready -> A then B delivered, in_ready=1 one cycle after A leaves.
REQ-034 SKID=0, out_ready=0 with one entry -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> replace in one cycle, no bubble.
REQ-035 Stage at occupancy 2, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_data=BUBBLE_VAL, incoming payload not delivered.
REQ-036 rst asserted while occupancy=2 -> next cycle out_valid=0, occupancy 0, in_ready=0; deassert -> in_ready=1 next cycle.
REQ-037 Random in_valid/out_ready/flush for 10k cycles, WIDTH=64, both SKID values -> scoreboard: ordered, no loss except flushed, out_data stable under stall.
